// File: rtl/pipe_stage_buf.sv
// In-order DEPTH-entry pipeline buffer with valid/allow_in handshakes, a per-entry
// head residency latency, synchronous flush and occupancy output.
module pipe_stage_buf #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 2,
  parameter int LAT    = 0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         in_valid,
  input  logic [DATA_W-1:0]            in_data,
  output logic                         in_allow,
  output logic                         out_valid,
  output logic [DATA_W-1:0]            out_data,
  input  logic                         out_allow_in,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LAT_W = (LAT > 0) ? $clog2(LAT + 1) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(LAT);

  // Register-based storage: reset must clear it and the head is read combinationally.
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [LAT_W-1:0] lat_cnt_q, lat_cnt_d;
  logic             ready_go;
  logic             in_fire;
  logic             out_fire;
  logic             head_load;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  assign ready_go  = (lat_cnt_q == '0);
  assign out_valid = (count_q != '0) && ready_go && !flush;
  assign in_allow  = !flush && ((count_q < CNT_FULL) || (ready_go && out_allow_in));
  assign in_fire   = in_valid && in_allow;
  assign out_fire  = out_valid && out_allow_in;
  assign out_data  = mem_q[rd_ptr_q];
  assign count     = count_q;

  always_comb begin
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    count_d   = count_q;
    lat_cnt_d = lat_cnt_q;
    head_load = 1'b0;
    if (flush) begin
      rd_ptr_d  = '0;
      wr_ptr_d  = '0;
      count_d   = '0;
      lat_cnt_d = '0;
    end else begin
      if (in_fire) begin
        wr_ptr_d = ptr_inc(wr_ptr_q);
      end
      if (out_fire) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      if (in_fire && !out_fire) begin
        count_d = count_q + 1'b1;
      end else if (!in_fire && out_fire) begin
        count_d = count_q - 1'b1;
      end
      // A new head appears on enqueue into empty, or on a dequeue that leaves something behind.
      head_load = (in_fire && (count_q == '0)) ||
                  (out_fire && ((count_q != CNT_ONE) || in_fire));
      if (head_load) begin
        lat_cnt_d = LAT_LOAD;
      end else if (lat_cnt_q != '0) begin
        lat_cnt_d = lat_cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      lat_cnt_q <= '0;
    end else begin
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      lat_cnt_q <= lat_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (in_fire) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Randomized scoreboard bench for pipe_stage_buf running three configurations in parallel
// against a queue-and-timestamp reference model.
module tb_pipe_stage_buf;

  localparam int NCFG = 3;
  localparam int DW   = 16;
  localparam int DEP_C [NCFG] = '{1, 3, 2};
  localparam int LAT_C [NCFG] = '{0, 0, 3};
  localparam int NCYC = 3000;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic flush = 1'b0;

  logic [NCFG-1:0]         in_valid_v  = '0;
  logic [NCFG-1:0]         out_allow_v = '0;
  logic [NCFG-1:0][DW-1:0] in_data_v   = '0;
  logic [NCFG-1:0]         in_allow_v;
  logic [NCFG-1:0]         out_valid_v;
  logic [NCFG-1:0][DW-1:0] out_data_v;
  logic [NCFG-1:0][3:0]    count_v;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < NCFG; gi++) begin : g_dut
    localparam int CW = $clog2(DEP_C[gi] + 1);
    logic [CW-1:0] cnt_w;
    logic          ia_w;
    logic          ov_w;
    logic [DW-1:0] od_w;

    pipe_stage_buf #(
      .DATA_W(DW),
      .DEPTH (DEP_C[gi]),
      .LAT   (LAT_C[gi])
    ) u_dut (
      .clk         (clk),
      .reset       (reset),
      .flush       (flush),
      .in_valid    (in_valid_v[gi]),
      .in_data     (in_data_v[gi]),
      .in_allow    (ia_w),
      .out_valid   (ov_w),
      .out_data    (od_w),
      .out_allow_in(out_allow_v[gi]),
      .count       (cnt_w)
    );

    assign in_allow_v[gi]  = ia_w;
    assign out_valid_v[gi] = ov_w;
    assign out_data_v[gi]  = od_w;
    assign count_v[gi]     = 4'(cnt_w);
  end

  // Reference model: entries in arrival order, plus the cycle at which the current head took over.
  logic [DW-1:0] exp_q [NCFG][$];
  longint        head_since [NCFG];
  bit            mem_zero [NCFG];
  longint        cyc = 0;
  bit            armed = 1'b0;
  int            n_checks = 0;
  int            n_fail = 0;
  int            n_xfer = 0;

  task automatic chk(input string nm, input int cfg, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cfg%0d cyc%0d: got %0h expected %0h", nm, cfg, cyc, got, exp);
    end
  endtask

  always @(negedge clk) begin : mon
    int sz;
    bit rdy, e_ov, e_ia, inf, outf;
    for (int i = 0; i < NCFG; i++) begin
      sz   = exp_q[i].size();
      rdy  = (sz > 0) && ((cyc - head_since[i]) >= longint'(LAT_C[i]));
      e_ov = (sz > 0) && rdy && !flush;
      e_ia = !flush && ((sz < DEP_C[i]) || (rdy && out_allow_v[i]));
      inf  = in_valid_v[i] && e_ia;
      outf = e_ov && out_allow_v[i];
      if (armed) begin
        chk("out_valid", i, 32'(out_valid_v[i]), 32'(e_ov));
        chk("in_allow", i, 32'(in_allow_v[i]), 32'(e_ia));
        chk("count", i, 32'(count_v[i]), 32'(sz));
        if (e_ov) begin
          chk("out_data", i, 32'(out_data_v[i]), 32'(exp_q[i][0]));
        end
        if (sz == 0 && mem_zero[i]) begin
          chk("out_data_cleared", i, 32'(out_data_v[i]), 32'h0);
        end
      end
      if (reset) begin
        exp_q[i].delete();
        head_since[i] = cyc + 1;
        mem_zero[i] = 1'b1;
      end else if (flush) begin
        exp_q[i].delete();
      end else begin
        if (outf) begin
          if (!reset && armed) begin
            n_xfer++;
            $display("cfg%0d cyc%0d out %04h", i, cyc, exp_q[i][0]);
          end
          void'(exp_q[i].pop_front());
        end
        if (inf) begin
          exp_q[i].push_back(in_data_v[i]);
          mem_zero[i] = 1'b0;
        end
        if ((inf && sz == 0) || (outf && exp_q[i].size() > 0)) begin
          head_since[i] = cyc + 1;
        end
      end
    end
    if (reset) armed = 1'b1;
    cyc++;
  end

  initial begin
    int pv, pa;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    for (int c = 0; c < NCYC; c++) begin
      @(posedge clk);
      #1;
      case (c / 500)
        0:       begin pv = 100; pa = 100; end
        1:       begin pv = 80;  pa = 15;  end
        2:       begin pv = 30;  pa = 90;  end
        3:       begin pv = 50;  pa = 50;  end
        default: begin pv = 90;  pa = 60;  end
      endcase
      for (int i = 0; i < NCFG; i++) begin
        in_valid_v[i]  = ($urandom_range(0, 99) < pv);
        out_allow_v[i] = ($urandom_range(0, 99) < pa);
        in_data_v[i]   = DW'($urandom);
      end
      flush = (c >= 1000) && ($urandom_range(0, 99) < 3);
      reset = (c == 1700) || (c == 2450) || (c == 2803);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    flush = 1'b0;
    in_valid_v  = '0;
    out_allow_v = '1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    #1;
    if (n_xfer == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL no_transfers: got 0 expected nonzero");
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
